// File: rtl/process_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : process_scheduler
//  Description : Round-robin scheduler that time-shares the processor between
//                user programs held in a slot table. BIOS registers entry PCs,
//                then pulses release_req. The scheduler dispatches one slot,
//                counts its quantum, preempts at an instruction boundary on
//                expiry or HALT, saves the PC and hands control back to BIOS.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_PROC         number of process slots (power of two, 2..16)
//    PID_W            slot id width, log2(NUM_PROC)
//  Ports
//    clk              system clock, all state updates on posedge
//    rst_n            asynchronous active-low reset
//    add_valid/add_pc register a new process at its entry PC
//    add_ready        at least one free slot exists
//    add_id           slot an accepted add will occupy (lowest free)
//    release_req      BIOSINT pulse from BIOS: start scheduling
//    quantum          slice length in cycles, 0 disables preemption
//    lock             running process holds LOCK, defers quantum preemption
//    halt             running process executed HALT (1-cycle pulse)
//    done_inst        processor is at an instruction boundary
//    cur_pc           processor PC, sampled when the slot is saved
//    dispatch         1-cycle pulse: processor loads dispatch_pc
//    dispatch_pc      PC to load, valid while dispatch=1
//    run_id           slot currently or last dispatched
//    running          a process owns the processor
//    bios_mode        BIOS owns the processor
//    quantum_used     cycles consumed in the current slice (saturating)
//  Optional (macro SCHED_STATS_EN)
//    ctx_switch_count number of slot saves, wraps at 2^32
//    halt_count       number of saves caused by HALT, wraps at 2^32
// ============================================================================
module process_scheduler #(
  parameter int NUM_PROC = 8,
  parameter int PID_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_valid,
  input  logic [31:0]      add_pc,
  output logic             add_ready,
  output logic [PID_W-1:0] add_id,
  input  logic             release_req,
  input  logic [31:0]      quantum,
  input  logic             lock,
  input  logic             halt,
  input  logic             done_inst,
  input  logic [31:0]      cur_pc,
  output logic             dispatch,
  output logic [31:0]      dispatch_pc,
  output logic [PID_W-1:0] run_id,
  output logic             running,
  output logic             bios_mode,
`ifdef SCHED_STATS_EN
  output logic [31:0]      ctx_switch_count,
  output logic [31:0]      halt_count,
`endif
  output logic [31:0]      quantum_used
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PICK     = 3'd1,
    S_DISPATCH = 3'd2,
    S_RUN      = 3'd3,
    S_DRAIN    = 3'd4,
    S_SAVE     = 3'd5
  } state_t;

  // After reset the pointer sits on the last slot so the first scan starts
  // at slot 0.
  localparam logic [PID_W-1:0] c_PTR_INIT = PID_W'(NUM_PROC - 1);

  state_t              r_state;
  state_t              w_next;

  logic [NUM_PROC-1:0] r_valid;
  logic [31:0]         r_saved_pc [NUM_PROC];
  logic [PID_W-1:0]    r_rr_ptr;
  logic [PID_W-1:0]    r_run_id;
  logic                r_halt_lat;
  logic [31:0]         r_quantum_used;

  logic [PID_W-1:0]    w_add_id;
  logic                w_add_fire;
  logic [PID_W-1:0]    w_pick_id;
  logic                w_pick_found;
  logic [PID_W-1:0]    w_scan_idx;
  logic                w_expired;
  logic                w_run_exit;
  logic                w_halt_seen;

  // --------------------------------------------------------------------------
  // Free-slot search: lowest index whose valid bit is clear. Computed from
  // the registered valid vector, so a slot being cleared by SAVE this cycle
  // is not offered to an add until the following cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_add_id = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_add_id = PID_W'(i);
      end
    end
  end

  assign add_ready  = ~(&r_valid);
  assign add_id     = w_add_id;
  assign w_add_fire = add_valid & add_ready;

  // --------------------------------------------------------------------------
  // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... with natural wrap of the
  // PID_W-bit sum. Iterating from the far end down lets the nearest valid
  // slot overwrite any farther candidate.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pick_id    = '0;
    w_pick_found = 1'b0;
    w_scan_idx   = '0;
    for (int i = NUM_PROC; i >= 1; i--) begin
      w_scan_idx = r_rr_ptr + PID_W'(i);
      if (r_valid[w_scan_idx]) begin
        w_pick_id    = w_scan_idx;
        w_pick_found = 1'b1;
      end
    end
  end

  // Lock only stretches the slice; halt always ends it.
  assign w_expired   = (quantum != 32'd0) && (r_quantum_used >= quantum);
  assign w_run_exit  = halt | (w_expired & ~lock);
  assign w_halt_seen = halt && ((r_state == S_RUN) || (r_state == S_DRAIN));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    dispatch    = 1'b0;
    dispatch_pc = 32'd0;
    running     = 1'b0;
    bios_mode   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bios_mode = 1'b1;
        if (release_req && (|r_valid)) begin
          w_next = S_PICK;
        end
      end
      S_PICK: begin
        bios_mode = 1'b1;
        w_next    = w_pick_found ? S_DISPATCH : S_IDLE;
      end
      S_DISPATCH: begin
        // run_id already holds the picked slot.
        dispatch    = 1'b1;
        dispatch_pc = r_saved_pc[r_run_id];
        w_next      = S_RUN;
      end
      S_RUN: begin
        running = 1'b1;
        if (w_run_exit) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        running = 1'b1;
        if (done_inst) begin
          w_next = S_SAVE;
        end
      end
      S_SAVE: begin
        running = 1'b1;
        w_next  = S_IDLE;
      end
      default: begin
        bios_mode = 1'b1;
        w_next    = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slot table, pointer, halt latch and slice counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= '0;
      r_rr_ptr       <= c_PTR_INIT;
      r_run_id       <= '0;
      r_halt_lat     <= 1'b0;
      r_quantum_used <= 32'd0;
      for (int i = 0; i < NUM_PROC; i++) begin
        r_saved_pc[i] <= 32'd0;
      end
    end else begin
      // An add never targets the slot being saved: run_id is valid, add_id
      // is not.
      if (w_add_fire) begin
        r_valid[w_add_id]    <= 1'b1;
        r_saved_pc[w_add_id] <= add_pc;
      end

      if (r_state == S_SAVE) begin
        if (r_halt_lat) begin
          r_valid[r_run_id] <= 1'b0;
        end else begin
          r_saved_pc[r_run_id] <= cur_pc;
        end
        r_rr_ptr <= r_run_id;
      end

      if (r_state == S_SAVE) begin
        r_halt_lat <= 1'b0;
      end else if (w_halt_seen) begin
        r_halt_lat <= 1'b1;
      end

      if ((r_state == S_PICK) && w_pick_found) begin
        r_run_id <= w_pick_id;
      end

      case (r_state)
        S_PICK: begin
          if (w_pick_found) begin
            r_quantum_used <= 32'd0;
          end
        end
        S_DISPATCH: begin
          r_quantum_used <= 32'd0;
        end
        S_RUN, S_DRAIN: begin
          if (r_quantum_used != 32'hFFFF_FFFF) begin
            r_quantum_used <= r_quantum_used + 32'd1;
          end
        end
        default: begin
          r_quantum_used <= r_quantum_used;
        end
      endcase
    end
  end

  assign run_id       = r_run_id;
  assign quantum_used = r_quantum_used;

`ifdef SCHED_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics counters, free-running with natural 32-bit wrap
  // --------------------------------------------------------------------------
  logic [31:0] r_ctx_switch_count;
  logic [31:0] r_halt_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctx_switch_count <= 32'd0;
      r_halt_count       <= 32'd0;
    end else if (r_state == S_SAVE) begin
      r_ctx_switch_count <= r_ctx_switch_count + 32'd1;
      if (r_halt_lat) begin
        r_halt_count <= r_halt_count + 32'd1;
      end
    end
  end

  assign ctx_switch_count = r_ctx_switch_count;
  assign halt_count       = r_halt_count;
`endif

endmodule
`default_nettype wire

// File: doc/process_scheduler.md
Name: process_scheduler

Overview:
Round-robin process scheduler that time-shares the processor between user programs held in a slot table.
- Sits beside the BIOS controller.
- BIOS registers process entry PCs, then releases execution.
- Scheduler dispatches a slot, counts its quantum, and preempts at an instruction boundary on expiry or HALT.
- Saves the PC, then returns control to BIOS mode.

Parameters:
NUM_PROC, 8, number of process slots (power of two, 2..16)
PID_W, 3, slot id width, equal to log2(NUM_PROC)

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
add_valid  in  1  request to register a new process
add_pc  in  32  entry PC of the new process
add_ready  out  1  at least one free slot exists
add_id  out  PID_W  slot that an accepted add will occupy (lowest free)
release  in  1  BIOSINT pulse from BIOS: start scheduling
quantum  in  32  slice length in cycles; 0 = no preemption
lock  in  1  LOCK held by running process; defers quantum preemption
halt  in  1  running process executed HALT (1-cycle pulse)
done_inst  in  1  processor at instruction boundary
cur_pc  in  32  processor PC, sampled at save
dispatch  out  1  1-cycle pulse: processor loads dispatch_pc
dispatch_pc  out  32  PC to load, valid while dispatch=1
run_id  out  PID_W  slot currently or last dispatched
running  out  1  a process owns the processor
bios_mode  out  1  BIOS owns the processor (controll)
quantum_used  out  32  cycles consumed in current slice

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; all slot valid bits 0.
  - rr_ptr=NUM_PROC-1; bios_mode=1.
  - dispatch=0, dispatch_pc=0, run_id=0, running=0, quantum_used=0.
  - add_ready=1, add_id=0.
- Slot table: per slot a valid bit and a 32-bit saved_pc.
  - add_ready = |~valid.
  - add_id = lowest index with valid=0.
- Add: add_valid & add_ready at posedge sets valid[add_id] and saved_pc=add_pc. Accepted in every state.
  - add_valid with add_ready=0 is dropped.
- FSM states: IDLE, PICK, DISPATCH, RUN, DRAIN, SAVE.
- IDLE:
  - bios_mode=1, running=0.
  - release & any valid -> PICK.
  - release with no valid slot is ignored.
- PICK (1 cycle): select the first valid slot scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_PROC, then -> DISPATCH.
  - If no slot is valid (all removed), -> IDLE.
- DISPATCH (1 cycle):
  - dispatch=1, dispatch_pc=saved_pc[sel], run_id=sel.
  - bios_mode=0; quantum_used cleared to 0.
  - Then -> RUN.
- RUN:
  - running=1; quantum_used increments by 1 per cycle, saturating at 0xFFFFFFFF.
  - Exit condition: halt=1, or (quantum!=0 & quantum_used>=quantum & lock=0). On exit -> DRAIN; a halt cause is latched.
  - halt wins over lock. Lock only stretches the slice; preemption fires on the first cycle lock=0 with the slice expired.
- DRAIN:
  - running=1; quantum_used keeps counting.
  - A halt arriving here is also latched.
  - done_inst=1 -> SAVE; evaluated the same cycle DRAIN is entered.
- SAVE (1 cycle):
  - If the halt cause is latched, clear valid[run_id]; otherwise saved_pc[run_id]=cur_pc.
  - rr_ptr=run_id; clear the halt latch; -> IDLE.
  - running=0 and bios_mode=1 from the next cycle.
- Simultaneous events:
  - An add and a SAVE clear in the same cycle touch different slots, because add_id is computed from the pre-clear valid vector.
  - A halted slot becomes free the cycle after SAVE.
- halt outside RUN/DRAIN is ignored.
- release outside IDLE is ignored.
- Reset mid-slice abandons the process: all slots become invalid.

Optional Feature:
SCHED_STATS_EN:
- When defined, adds outputs ctx_switch_count (32) and halt_count (32). Both reset to 0.
  - ctx_switch_count increments on every SAVE.
  - halt_count increments on every SAVE with the halt cause latched.
  - Both wrap at 2^32.
- When not defined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, add pc=0x10 then pc=0x40, pulse release -> dispatch with dispatch_pc=0x10, run_id=0; bios_mode=0 on the dispatch cycle.
- quantum=5, done_inst=1 always -> RUN lasts until quantum_used=5, then DRAIN, SAVE stores cur_pc into slot 0; next release dispatches slot 1 at 0x40.
- quantum=5, lock=1 held for 10 cycles of RUN -> no preemption until lock falls; preempt on the first unlocked cycle; quantum_used>=10 at exit.
- halt during RUN with done_inst low for 3 cycles -> remains in DRAIN 3 cycles; SAVE clears valid[run_id]; add_id returns that slot next cycle.
- Fill all 8 slots -> add_ready=0; a 9th add_valid is dropped; halting slot 3 restores add_ready=1, add_id=3.
- Assert rst_n=0 asynchronously mid-RUN -> running=0, bios_mode=1, add_ready=1 immediately, without waiting for a clock edge.
